ecd_request_scheduler: RTL and testbench
========================================

ECD_REQUEST_SCHEDULER -- requirements
Module: ecd_request_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 256, width of every message bus.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, cycles to wait for a response before one is synthesized; legal range 2 to 2^24-1.
REQ-003 clk  in  1  single clock; every register is clocked on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 AXIS_REQ0_TDATA/TVALID/TREADY  in/in/out  DATA_WIDTH/1/1  AXI4-Lite request messages from requester 0 (host).
REQ-006 AXIS_REQ1_TDATA/TVALID/TREADY  in/in/out  DATA_WIDTH/1/1  AXI4-Lite request messages from requester 1 (internal poller).
REQ-007 AXIS_TX_TDATA/TVALID/TREADY  out/out/in  DATA_WIDTH/1/1  the granted request, sent to the ECD.
REQ-008 AXIS_RSP_TDATA/TVALID/TREADY  in/in/out  DATA_WIDTH/1/1  AXI4-Lite responses arriving from the event broker.
REQ-009 AXIS_RSP0_TDATA/TVALID/TREADY  out/out/in  DATA_WIDTH/1/1  responses returned to requester 0.
REQ-010 AXIS_RSP1_TDATA/TVALID/TREADY  out/out/in  DATA_WIDTH/1/1  responses returned to requester 1.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 timeout_count  out  16  number of synthesized timeout responses; saturates at 0xFFFF.
REQ-013 stray_count  out  16  number of responses discarded in IDLE; saturates at 0xFFFF.

Function
REQ-014 The block SHALL keep at most one request outstanding, using a four-state FSM: IDLE, SEND, WAIT_RSP, DELIVER.
REQ-015 IDLE, arbitration:
- one requester valid: it is selected;
- both valid: select the requester not granted last (round-robin); after reset, requester 0 wins the first tie.
REQ-016 AXIS_REQn_TREADY SHALL be high only in IDLE, only for the selected requester, and SHALL be combinational from state and the TVALIDs.
REQ-017 On a REQ handshake the block SHALL:
- register TDATA into AXIS_TX_TDATA and record the grant;
- assert AXIS_TX_TVALID on the next cycle;
- move to SEND.
Latency from REQ handshake to TX_TVALID is 1 cycle.
REQ-018 SEND: on a TX handshake, deassert TX_TVALID, clear the timer, move to WAIT_RSP; TX_TDATA SHALL stay stable while TVALID is high.
REQ-019 WAIT_RSP:
- AXIS_RSP_TREADY is high and the timer increments every cycle;
- on an RSP handshake, register TDATA into the granted RSPn output, assert RSPn_TVALID next cycle, move to DELIVER.
REQ-020 Timeout: when the timer reaches TIMEOUT_CYCLES with no RSP handshake, the block SHALL:
- load the granted RSPn_TDATA with bits[7:0]=0xFF and all other bits 0;
- assert RSPn_TVALID, increment timeout_count, move to DELIVER.
REQ-021 If an RSP handshake and timer expiry fall in the same cycle, the real response SHALL win and timeout_count SHALL NOT change.
REQ-022 DELIVER:
- AXIS_RSP_TREADY is low;
- on the RSPn handshake, deassert RSPn_TVALID and return to IDLE;
- the non-granted RSP output never asserts TVALID.
REQ-023 In IDLE, AXIS_RSP_TREADY SHALL be high; any response accepted there is discarded and increments stray_count.
REQ-024 In SEND, AXIS_RSP_TREADY SHALL be low.
REQ-025 Back-to-back requests SHALL go through IDLE for at least one cycle between DELIVER and the next grant.

Reset
REQ-026 While reset is high, the block SHALL:
- force state to IDLE and clear the grant history (requester 0 wins the next tie);
- clear the timer, timeout_count and stray_count;
- drive AXIS_TX_TVALID, AXIS_RSP0_TVALID, AXIS_RSP1_TVALID and busy to 0.
REQ-027 While reset is high, AXIS_REQ0/1_TREADY and AXIS_RSP_TREADY SHALL be 0.
REQ-028 Data registers need no reset value.
REQ-029 Reset asserted mid-transaction SHALL abandon it with no response delivered; a later response is treated as a stray.

Structure
REQ-030 A shared package SHALL hold:
- FSM state encoding;
- message-type constants (0 = AXI4-Lite response, 1 = event);
- the timeout error code 0xFF;
- the counter width 16.
REQ-031 Round-robin selection SHALL be one sub-module, ecd_rr_arbiter2 (inputs: two valids, last-grant bit; outputs: one-hot select).
REQ-032 Timer width SHALL be 24 bits.

Verification
REQ-033 Single request: REQ0 sends 0xA5, TX_TREADY=1, response 0x1234 after 10 cycles -> TX_TVALID 1 cycle after the REQ handshake; RSP0 carries 0x1234; RSP1_TVALID stays 0.
REQ-034 Tie: REQ0 and REQ1 valid together, repeated 4 times -> grant order 0,1,0,1.
REQ-035 Timeout with TIMEOUT_CYCLES=16 and no response -> after 16 WAIT_RSP cycles, RSP1 gets bits[7:0]=0xFF; timeout_count=1.
REQ-036 Response on the exact expiry cycle -> real data delivered; timeout_count unchanged.
REQ-037 Late response after a timeout, arriving in IDLE -> discarded; stray_count=1; no RSPn_TVALID.
REQ-038 Reset pulsed in WAIT_RSP, then backpressure held on TX and RSPn for 5 cycles -> all outputs at reset values; then data held stable and no handshakes lost.

Source files
------------

// File: rtl/ecd_request_scheduler_pkg.sv
// Shared types and constants for the ECD request scheduler.
`timescale 1ns/1ps
package ecd_request_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DELIVER  = 2'd3
    } state_e;

    localparam logic MSG_AXIL_RSP = 1'b0;
    localparam logic MSG_EVENT    = 1'b1;

    localparam logic [7:0] TIMEOUT_CODE = 8'hFF;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMER_W = 24;

    // Saturating increment for the status counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/ecd_request_scheduler_rr_arbiter.sv
// Two-way round-robin arbiter: a tie goes to the requester not granted last.
`timescale 1ns/1ps
module ecd_rr_arbiter2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] sel_c
);

    always_comb begin
        sel_c = 2'b00;
        if (valid0 && valid1) begin
            sel_c = last_grant ? 2'b01 : 2'b10;
        end else if (valid0) begin
            sel_c = 2'b01;
        end else if (valid1) begin
            sel_c = 2'b10;
        end
    end

endmodule

// File: rtl/ecd_request_scheduler.sv
// Single-outstanding request scheduler between two requesters and the ECD,
// with response routing, timeout synthesis and stray-response accounting.
`timescale 1ns/1ps
module ecd_request_scheduler
    import ecd_request_scheduler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [DATA_WIDTH-1:0] AXIS_REQ0_TDATA,
    input  logic                  AXIS_REQ0_TVALID,
    output logic                  AXIS_REQ0_TREADY,

    input  logic [DATA_WIDTH-1:0] AXIS_REQ1_TDATA,
    input  logic                  AXIS_REQ1_TVALID,
    output logic                  AXIS_REQ1_TREADY,

    output logic [DATA_WIDTH-1:0] AXIS_TX_TDATA,
    output logic                  AXIS_TX_TVALID,
    input  logic                  AXIS_TX_TREADY,

    input  logic [DATA_WIDTH-1:0] AXIS_RSP_TDATA,
    input  logic                  AXIS_RSP_TVALID,
    output logic                  AXIS_RSP_TREADY,

    output logic [DATA_WIDTH-1:0] AXIS_RSP0_TDATA,
    output logic                  AXIS_RSP0_TVALID,
    input  logic                  AXIS_RSP0_TREADY,

    output logic [DATA_WIDTH-1:0] AXIS_RSP1_TDATA,
    output logic                  AXIS_RSP1_TVALID,
    input  logic                  AXIS_RSP1_TREADY,

    output logic                  busy,
    output logic [CNT_W-1:0]      timeout_count,
    output logic [CNT_W-1:0]      stray_count
);

    state_e              state_q;
    state_e              state_d;
    logic                last_grant_q;
    logic [TIMER_W-1:0]  timer_q;
    logic [1:0]          sel_c;
    logic                req_hs_c;
    logic                tx_hs_c;
    logic                rsp_hs_c;
    logic                out_hs_c;
    logic                expire_c;
    logic [DATA_WIDTH-1:0] rsp_word_c;

    ecd_rr_arbiter2 u_arb (
        .valid0     (AXIS_REQ0_TVALID),
        .valid1     (AXIS_REQ1_TVALID),
        .last_grant (last_grant_q),
        .sel_c      (sel_c)
    );

    // Ready signals are decoded straight from state; all held low in reset.
    always_comb begin
        AXIS_REQ0_TREADY = !reset && (state_q == ST_IDLE) && sel_c[0];
        AXIS_REQ1_TREADY = !reset && (state_q == ST_IDLE) && sel_c[1];
        AXIS_RSP_TREADY  = !reset && ((state_q == ST_IDLE) || (state_q == ST_WAIT_RSP));
    end

    assign req_hs_c   = (AXIS_REQ0_TVALID && AXIS_REQ0_TREADY) ||
                        (AXIS_REQ1_TVALID && AXIS_REQ1_TREADY);
    assign tx_hs_c    = AXIS_TX_TVALID && AXIS_TX_TREADY;
    assign rsp_hs_c   = AXIS_RSP_TVALID && AXIS_RSP_TREADY;
    assign out_hs_c   = (AXIS_RSP0_TVALID && AXIS_RSP0_TREADY) ||
                        (AXIS_RSP1_TVALID && AXIS_RSP1_TREADY);
    // Expiry on the TIMEOUT_CYCLES-th cycle spent in WAIT_RSP.
    assign expire_c   = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign rsp_word_c = rsp_hs_c ? AXIS_RSP_TDATA : DATA_WIDTH'(TIMEOUT_CODE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (req_hs_c)             state_d = ST_SEND;
            ST_SEND:     if (tx_hs_c)              state_d = ST_WAIT_RSP;
            ST_WAIT_RSP: if (rsp_hs_c || expire_c) state_d = ST_DELIVER;
            ST_DELIVER:  if (out_hs_c)             state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // Control state: FSM, grant history, timer, valids and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            last_grant_q     <= 1'b1;
            timer_q          <= '0;
            timeout_count    <= '0;
            stray_count      <= '0;
            AXIS_TX_TVALID   <= 1'b0;
            AXIS_RSP0_TVALID <= 1'b0;
            AXIS_RSP1_TVALID <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (req_hs_c) begin
                        AXIS_TX_TVALID <= 1'b1;
                        last_grant_q   <= sel_c[1];
                    end
                    if (rsp_hs_c) begin
                        stray_count <= sat_inc(stray_count);
                    end
                end
                ST_SEND: begin
                    if (tx_hs_c) begin
                        AXIS_TX_TVALID <= 1'b0;
                        timer_q        <= '0;
                    end
                end
                ST_WAIT_RSP: begin
                    timer_q <= timer_q + TIMER_W'(1);
                    if (rsp_hs_c || expire_c) begin
                        if (last_grant_q) AXIS_RSP1_TVALID <= 1'b1;
                        else              AXIS_RSP0_TVALID <= 1'b1;
                    end
                    // A real response on the expiry cycle wins over the timeout.
                    if (expire_c && !rsp_hs_c) begin
                        timeout_count <= sat_inc(timeout_count);
                    end
                end
                ST_DELIVER: begin
                    if (out_hs_c) begin
                        AXIS_RSP0_TVALID <= 1'b0;
                        AXIS_RSP1_TVALID <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload registers carry no reset; they are qualified by the valids.
    always_ff @(posedge clk) begin
        if (req_hs_c) begin
            AXIS_TX_TDATA <= sel_c[1] ? AXIS_REQ1_TDATA : AXIS_REQ0_TDATA;
        end
        if ((state_q == ST_WAIT_RSP) && (rsp_hs_c || expire_c)) begin
            if (last_grant_q) AXIS_RSP1_TDATA <= rsp_word_c;
            else              AXIS_RSP0_TDATA <= rsp_word_c;
        end
    end

endmodule

// File: tb/tb_ecd_request_scheduler.sv
// Randomized scoreboard bench for ecd_request_scheduler.
`timescale 1ns/1ps
module tb_ecd_request_scheduler;

    localparam int unsigned DW = 64;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] req0_data, req1_data, tx_data, rsp_data, r0_data, r1_data;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic          tx_valid, tx_ready, rsp_valid, rsp_ready;
    logic          r0_valid, r0_ready, r1_valid, r1_ready;
    logic          busy;
    logic [15:0]   timeout_count, stray_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_tx_q[$];
    logic [DW-1:0] exp_r0_q[$];
    logic [DW-1:0] exp_r1_q[$];
    int last_m = 1;
    int to_m   = 0;
    int st_m   = 0;

    always #5 clk = ~clk;

    ecd_request_scheduler #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .AXIS_REQ0_TDATA  (req0_data),
        .AXIS_REQ0_TVALID (req0_valid),
        .AXIS_REQ0_TREADY (req0_ready),
        .AXIS_REQ1_TDATA  (req1_data),
        .AXIS_REQ1_TVALID (req1_valid),
        .AXIS_REQ1_TREADY (req1_ready),
        .AXIS_TX_TDATA    (tx_data),
        .AXIS_TX_TVALID   (tx_valid),
        .AXIS_TX_TREADY   (tx_ready),
        .AXIS_RSP_TDATA   (rsp_data),
        .AXIS_RSP_TVALID  (rsp_valid),
        .AXIS_RSP_TREADY  (rsp_ready),
        .AXIS_RSP0_TDATA  (r0_data),
        .AXIS_RSP0_TVALID (r0_valid),
        .AXIS_RSP0_TREADY (r0_ready),
        .AXIS_RSP1_TDATA  (r1_data),
        .AXIS_RSP1_TVALID (r1_valid),
        .AXIS_RSP1_TREADY (r1_ready),
        .busy             (busy),
        .timeout_count    (timeout_count),
        .stray_count      (stray_count)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever an output stream is valid its data must match the
    // head of its expected queue; the entry retires on the handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_valid) begin
                if (exp_tx_q.size() == 0) chk("tx_unexpected_valid", DW'(tx_valid), DW'(0));
                else begin
                    chk("tx_data", tx_data, exp_tx_q[0]);
                    if (tx_ready) void'(exp_tx_q.pop_front());
                end
            end
            if (r0_valid) begin
                if (exp_r0_q.size() == 0) chk("rsp0_unexpected_valid", DW'(r0_valid), DW'(0));
                else begin
                    chk("rsp0_data", r0_data, exp_r0_q[0]);
                    if (r0_ready) void'(exp_r0_q.pop_front());
                end
            end
            if (r1_valid) begin
                if (exp_r1_q.size() == 0) chk("rsp1_unexpected_valid", DW'(r1_valid), DW'(0));
                else begin
                    chk("rsp1_data", r1_data, exp_r1_q[0]);
                    if (r1_ready) void'(exp_r1_q.pop_front());
                end
            end
        end
    end

    // One full transaction. rsp_k = WAIT_RSP cycle (1..TO) carrying the
    // response; 0 means no response, so the timeout word is expected.
    task automatic do_txn(input bit v0, input bit v1, input logic [DW-1:0] d0,
                          input logic [DW-1:0] d1, input int rsp_k,
                          input logic [DW-1:0] rdata, input int tx_wait, input int out_wait);
        int  win;
        bit  got;
        bit  real_rsp;
        win = (v0 && v1) ? ((last_m == 1) ? 0 : 1) : (v1 ? 1 : 0);
        real_rsp = (rsp_k >= 1) && (rsp_k <= int'(TO));
        exp_tx_q.push_back((win == 1) ? d1 : d0);
        req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
        got = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("loser_tready", DW'((win == 1) ? req0_ready : req1_ready), DW'(0));
            if ((win == 1) ? req1_ready : req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL req_handshake: no TREADY for requester %0d within 8 cycles", win);
            req0_valid = 1'b0; req1_valid = 1'b0;
            exp_tx_q.delete();
            return;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        last_m = win;
        chk("tx_valid_latency", DW'(tx_valid), DW'(1));
        chk("busy_send", DW'(busy), DW'(1));
        chk("rsp_tready_send", DW'(rsp_ready), DW'(0));
        repeat (tx_wait) begin @(posedge clk); #1; end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        chk("tx_valid_drop", DW'(tx_valid), DW'(0));
        chk("rsp_tready_wait", DW'(rsp_ready), DW'(1));
        if (real_rsp) begin
            if (win == 1) exp_r1_q.push_back(rdata); else exp_r0_q.push_back(rdata);
            repeat (rsp_k - 1) begin @(posedge clk); #1; end
            rsp_valid = 1'b1; rsp_data = rdata;
            @(posedge clk); #1;
            rsp_valid = 1'b0;
        end else begin
            if (win == 1) exp_r1_q.push_back(DW'(8'hFF)); else exp_r0_q.push_back(DW'(8'hFF));
            to_m++;
            repeat (TO - 1) begin @(posedge clk); #1; end
            chk("rsp_before_expiry", DW'((win == 1) ? r1_valid : r0_valid), DW'(0));
            @(posedge clk); #1;
        end
        chk("rspn_valid", DW'((win == 1) ? r1_valid : r0_valid), DW'(1));
        chk("rsp_tready_deliver", DW'(rsp_ready), DW'(0));
        chk("timeout_count", DW'(timeout_count), DW'(to_m));
        repeat (out_wait) begin @(posedge clk); #1; end
        r0_ready = 1'b1; r1_ready = 1'b1;
        @(posedge clk); #1;
        r0_ready = 1'b0; r1_ready = 1'b0;
        chk("rspn_valid_drop", DW'((win == 1) ? r1_valid : r0_valid), DW'(0));
        chk("busy_idle", DW'(busy), DW'(0));
        chk("stray_count", DW'(stray_count), DW'(st_m));
    endtask

    // Response presented while idle: must be accepted and dropped.
    task automatic do_stray(input logic [DW-1:0] d);
        chk("rsp_tready_idle", DW'(rsp_ready), DW'(1));
        rsp_valid = 1'b1; rsp_data = d;
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        st_m++;
        chk("stray_count_inc", DW'(stray_count), DW'(st_m));
        chk("busy_stray", DW'(busy), DW'(0));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_valid"}, DW'(tx_valid), DW'(0));
        chk({tag, "_rsp0_valid"}, DW'(r0_valid), DW'(0));
        chk({tag, "_rsp1_valid"}, DW'(r1_valid), DW'(0));
        chk({tag, "_busy"}, DW'(busy), DW'(0));
        chk({tag, "_req0_tready"}, DW'(req0_ready), DW'(0));
        chk({tag, "_req1_tready"}, DW'(req1_ready), DW'(0));
        chk({tag, "_rsp_tready"}, DW'(rsp_ready), DW'(0));
        chk({tag, "_timeout_count"}, DW'(timeout_count), DW'(0));
        chk({tag, "_stray_count"}, DW'(stray_count), DW'(0));
    endtask

    // Reset while a request from requester 1 sits in WAIT_RSP.
    task automatic reset_mid_txn();
        req1_valid = 1'b1; req1_data = 64'hDEAD_0001;
        exp_tx_q.push_back(64'hDEAD_0001);
        for (int n = 0; n < 8 && !req1_ready; n++) @(negedge clk);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        exp_tx_q.delete(); exp_r0_q.delete(); exp_r1_q.delete();
        last_m = 1; to_m = 0; st_m = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] a, b, r;
        int v, rk;
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; tx_ready = 1'b0;
        rsp_valid = 1'b0; r0_ready = 1'b0; r1_ready = 1'b0;
        req0_data = '0; req1_data = '0; rsp_data = '0;
        repeat (3) begin @(posedge clk); #1; end
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Ties right after reset: grants alternate starting with requester 0.
        for (int i = 0; i < 4; i++)
            do_txn(1, 1, DW'(64'h100 + i), DW'(64'h200 + i), 3, DW'(64'h300 + i), 0, 0);

        do_txn(1, 0, DW'(8'hA5), DW'(0), 10, DW'(16'h1234), 0, 0);
        do_txn(0, 1, DW'(0), DW'(8'h5A), 0, DW'(0), 1, 1);
        do_txn(0, 1, DW'(0), DW'(8'h66), int'(TO), DW'(64'hBEEF_CAFE), 0, 2);
        do_txn(1, 0, DW'(8'h77), DW'(0), 0, DW'(0), 2, 0);
        do_stray(DW'(64'h0BAD_0BAD));

        for (int i = 0; i < 40; i++) begin
            v  = int'($urandom_range(1, 3));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            r  = {$urandom, $urandom};
            rk = int'($urandom_range(0, 9));
            rk = (rk == 0) ? 0 : (rk == 1) ? int'(TO) : int'($urandom_range(1, TO - 1));
            do_txn(v[0], v[1], a, b, rk, r, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 4) == 0) do_stray({$urandom, $urandom});
        end

        reset_mid_txn();
        do_stray(DW'(64'hDEAD_0002));
        do_txn(1, 1, DW'(64'hAAAA), DW'(64'hBBBB), 4, DW'(64'hCCCC), 5, 5);
        do_txn(1, 1, DW'(64'h1111), DW'(64'h2222), 0, DW'(0), 5, 5);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
